// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes
// and the datapath select codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] PC_4   = 2'b00;
   localparam logic [1:0] PC_IMM = 2'b01;
   localparam logic [1:0] PC_REG = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   function automatic logic op_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] imm_type(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_LUI, OP_AUIPC: return IMM_U;
         OP_JAL:           return IMM_J;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/fn3/fn7 -> aluop mapping, carried over from the
// single-cycle control.
module alu_decode
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4
) (
   input  logic [6:0]         opcode,
   input  logic [2:0]         fn3,
   input  logic [6:0]         fn7,
   output logic [ALUOP_W-1:0] aluop
);

   logic [3:0] fnop;
   logic [3:0] op4;
   logic       unused_fn7;

   assign unused_fn7 = ^{fn7[6], fn7[4:0]};

   always_comb begin
      fnop = ALU_ADD;
      case (fn3)
         // fn7[5] is an immediate bit for ADDI, so only R-type may subtract
         3'b000:  fnop = (opcode == OP_R && fn7[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  fnop = ALU_SLL;
         3'b010:  fnop = ALU_SLT;
         3'b011:  fnop = ALU_SLTU;
         3'b100:  fnop = ALU_XOR;
         3'b101:  fnop = fn7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  fnop = ALU_OR;
         default: fnop = ALU_AND;
      endcase

      op4 = ALU_ADD;
      case (opcode)
         OP_R, OP_I: op4 = fnop;
         OP_LUI:     op4 = ALU_PASSB;
         default:    op4 = ALU_ADD;
      endcase
   end

   assign aluop = ALUOP_W'(op4);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a waited
// memory handshake, illegal-opcode and bus-timeout traps, retire counter.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int ALUOP_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic [2:0]         fn3,
   input  logic [6:0]         fn7,
   input  logic               bt,
   input  logic               mack,
   output logic               mreq,
   output logic               mrd,
   output logic               mwr,
   output logic               irwr,
   output logic               werf,
   output logic               pcwr,
   output logic [ALUOP_W-1:0] aluop,
   output logic [1:0]         pcmux,
   output logic [1:0]         wbmux,
   output logic [2:0]         irmux,
   output logic               illegal,
   output logic               buserr,
   output logic [CNT_W-1:0]   instret
);

   localparam int WC_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t             state, nxt;
   logic [WC_W-1:0]    wcnt;
   logic [CNT_W-1:0]   cnt;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               ill_q, bus_q;
   logic               req, tmo, is_load, is_store;

   alu_decode #(.ALUOP_W(ALUOP_W)) u_alu_decode (
      .opcode (opcode),
      .fn3    (fn3),
      .fn7    (fn7),
      .aluop  (dec_aluop)
   );

   assign req      = (state == S_FETCH) || (state == S_MEM);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   // wcnt = wait cycles already spent; mack is still honoured when it equals MEM_TIMEOUT
   assign tmo      = (MEM_TIMEOUT != 0) && (wcnt == WC_W'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         wcnt  <= '0;
         ill_q <= 1'b0;
         bus_q <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= nxt;
         wcnt  <= (req && !mack) ? wcnt + 1'b1 : '0;
         if (state == S_DECODE && !op_legal(opcode)) ill_q <= 1'b1;
         if (req && !mack && tmo)                    bus_q <= 1'b1;
         if (pcwr)                                   cnt   <= cnt + 1'b1;
      end
   end

   always_comb begin
      nxt   = state;
      mreq  = 1'b0;
      mrd   = 1'b0;
      mwr   = 1'b0;
      irwr  = 1'b0;
      werf  = 1'b0;
      pcwr  = 1'b0;
      aluop = '0;
      pcmux = PC_4;
      wbmux = WB_ALU;
      irmux = IMM_I;

      if (state != S_FETCH && state != S_TRAP) begin
         aluop = dec_aluop;
         irmux = imm_type(opcode);
      end

      case (state)
         S_FETCH: begin
            mreq = 1'b1;
            mrd  = 1'b1;
            if (mack) begin
               irwr = 1'b1;
               nxt  = S_DECODE;
            end else if (tmo) begin
               nxt  = S_TRAP;
            end
         end
         S_DECODE: nxt = op_legal(opcode) ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (opcode)
               OP_BRANCH: begin
                  pcwr  = 1'b1;
                  pcmux = bt ? PC_IMM : PC_4;
                  nxt   = S_FETCH;
               end
               OP_JAL, OP_JALR: begin
                  werf  = 1'b1;
                  wbmux = WB_PC4;
                  pcwr  = 1'b1;
                  pcmux = (opcode == OP_JAL) ? PC_IMM : PC_REG;
                  nxt   = S_FETCH;
               end
               OP_LOAD, OP_STORE: nxt = S_MEM;
               default:           nxt = S_WB;
            endcase
         end
         S_MEM: begin
            mreq = 1'b1;
            mrd  = !is_store;
            mwr  = is_store;
            if (mack) begin
               if (is_store) begin
                  pcwr = 1'b1;
                  nxt  = S_FETCH;
               end else begin
                  nxt  = S_WB;
               end
            end else if (tmo) begin
               nxt = S_TRAP;
            end
         end
         S_WB: begin
            werf  = 1'b1;
            wbmux = is_load ? WB_MEM : WB_ALU;
            pcwr  = 1'b1;
            nxt   = S_FETCH;
         end
         default: nxt = S_TRAP;
      endcase

      // reset overrides everything so an aborted instruction never writes back
      if (rst) begin
         mreq  = 1'b0;
         mrd   = 1'b0;
         mwr   = 1'b0;
         irwr  = 1'b0;
         werf  = 1'b0;
         pcwr  = 1'b0;
         aluop = '0;
         pcmux = PC_4;
         wbmux = WB_ALU;
         irmux = IMM_I;
      end
   end

   assign illegal = ill_q & ~rst;
   assign buserr  = bus_q & ~rst;
   assign instret = rst ? '0 : cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction event-timing model
// checked every cycle, plus literal latency expectations.
module tb_multicycle_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    opcode = '0;
   logic [2:0]    fn3 = '0;
   logic [6:0]    fn7 = '0;
   logic          bt = 1'b0;
   logic          mack = 1'b0;
   logic          mreq, mrd, mwr, irwr, werf, pcwr, illegal, buserr;
   logic [3:0]    aluop;
   logic [1:0]    pcmux, wbmux;
   logic [2:0]    irmux;
   logic [CW-1:0] instret;

   multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO), .ALUOP_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .fn3(fn3), .fn7(fn7), .bt(bt),
      .mack(mack), .mreq(mreq), .mrd(mrd), .mwr(mwr), .irwr(irwr),
      .werf(werf), .pcwr(pcwr), .aluop(aluop), .pcmux(pcmux), .wbmux(wbmux),
      .irmux(irmux), .illegal(illegal), .buserr(buserr), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_AUI, C_JAL, C_JALR, C_BAD} cls_t;

   int total = 0, bad = 0;
   int cnt = 0, kcur = 0, pc_at = 0, ir_at = 0;
   logic [5:0] e_stb = '0;
   logic       e_ill = 1'b0, e_bus = 1'b0;
   logic [3:0] e_alu = '0;
   logic [1:0] e_pcm = '0, e_wbm = '0;
   logic [2:0] e_imm = '0;
   bit         c_alu = 0, c_sel = 0, c_imm = 0, chk = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d, t=%0t)", nm, act, exp, kcur, $time);
      end
   endtask

   function automatic cls_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUI;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         default:    return C_BAD;
      endcase
   endfunction

   function automatic logic [3:0] model_alu(input cls_t c, input logic [2:0] f3, input logic [6:0] f7);
      logic [3:0] tab [8];
      tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      if (c == C_LUI) return 4'd10;
      if (c != C_R && c != C_I) return 4'd0;
      if (f3 == 3'd5 && f7[5]) return 4'd7;
      if (f3 == 3'd0 && f7[5] && c == C_R) return 4'd1;
      return tab[f3];
   endfunction

   function automatic logic [2:0] model_imm(input cls_t c);
      case (c)
         C_ST:         return 3'b001;
         C_BR:         return 3'b010;
         C_LUI, C_AUI: return 3'b011;
         C_JAL:        return 3'b100;
         default:      return 3'b000;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk) begin
         check("strobes", 32'({mreq, mrd, mwr, irwr, werf, pcwr}), 32'(e_stb));
         check("flags", 32'({illegal, buserr}), 32'({e_ill, e_bus}));
         check("instret", 32'(instret), 32'(cnt));
         if (c_alu) check("aluop", 32'(aluop), 32'(e_alu));
         if (c_sel) begin
            check("pcmux", 32'(pcmux), 32'(e_pcm));
            check("wbmux", 32'(wbmux), 32'(e_wbm));
         end
         if (c_imm) check("irmux", 32'(irmux), 32'(e_imm));
         if (pcwr) pc_at = kcur;
         if (irwr) ir_at = kcur;
      end
   end

   task automatic do_rst(input int cyc);
      rst = 1'b1; mack = 1'b0;
      e_stb = '0; e_ill = 1'b0; e_bus = 1'b0;
      e_alu = '0; e_pcm = '0; e_wbm = '0; e_imm = '0;
      c_alu = 1; c_sel = 1; c_imm = 1;
      cnt = 0; kcur = 0; chk = 1;
      repeat (cyc) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   // fw/mw: wait cycles before mack in fetch/mem (beyond TMO = never acked).
   // ncyc > 0 truncates the run; lit_* are hand-derived irwr/pcwr cycles (0 = skip).
   task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic b, input int fw, input int mw, input int ncyc,
                      input bit noisy, input int lit_ir, input int lit_pc);
      cls_t c;
      bit   mem, fok, trap, inf, inm, last;
      int   lat, trap_at, n, mlast;
      c     = classify(op);
      mem   = (c == C_LD || c == C_ST);
      fok   = (fw <= TMO);
      lat   = ((c == C_LD) ? 5 : (c == C_BR || c == C_JAL || c == C_JALR) ? 3 : 4)
              + fw + (mem ? mw : 0);
      mlast = fw + 4 + ((mw < TMO) ? mw : TMO);
      if (!fok)                  trap_at = TMO + 2;
      else if (c == C_BAD)       trap_at = fw + 3;
      else if (mem && mw > TMO)  trap_at = mlast + 1;
      else                       trap_at = 0;
      n = (ncyc > 0) ? ncyc : lat;
      opcode = op; fn3 = f3; fn7 = f7; bt = b; pc_at = 0; ir_at = 0;
      for (int k = 1; k <= n; k++) begin
         trap = (trap_at != 0) && (k >= trap_at);
         inf  = !trap && (k <= ((fw < TMO) ? fw : TMO) + 1);
         inm  = !trap && mem && fok && (k >= fw + 4) && (k <= mlast);
         last = (trap_at == 0) && (k == lat);
         mack  = (fok && k == fw + 1) || (inm && k == fw + 4 + mw) || (noisy && !inf && !inm && !trap);
         e_stb = {inf || inm, inf || (inm && c == C_LD), inm && c == C_ST,
                  fok && k == fw + 1, last && c != C_ST && c != C_BR, last};
         e_ill = trap && fok && c == C_BAD;
         e_bus = trap && !e_ill;
         c_sel = last;
         e_wbm = (c == C_LD) ? 2'b01 : (c == C_JAL || c == C_JALR) ? 2'b10 : 2'b00;
         e_pcm = (c == C_BR) ? {1'b0, b} : (c == C_JAL) ? 2'b01 : (c == C_JALR) ? 2'b10 : 2'b00;
         c_alu = (trap_at == 0) && c != C_BR && c != C_JAL && c != C_JALR && c != C_BAD
                 && (k == fw + 3 || (last && !mem));
         e_alu = model_alu(c, f3, f7);
         c_imm = (trap_at == 0) && c != C_R && k >= fw + 2;
         e_imm = model_imm(c);
         kcur  = k;
         @(posedge clk); #1;
      end
      mack = 1'b0;
      if (trap_at == 0 && n >= lat) cnt = (cnt + 1) % (1 << CW);
      if (lit_ir > 0) check("irwr_cycle", 32'(ir_at), 32'(lit_ir));
      if (lit_pc > 0) check("pcwr_cycle", 32'(pc_at), 32'(lit_pc));
   endtask

   initial begin
      do_rst(2);
      //  opcode       fn3     fn7          bt fw mw ncyc noisy ir pc
      run(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // ADD
      run(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0, 1, 4);   // SUB
      run(7'b0000011, 3'b010, 7'b0000000, 0, 0, 2, 0, 0, 1, 7);   // LW, 2 mem waits
      run(7'b0100011, 3'b010, 7'b0000000, 0, 0, 2, 0, 0, 1, 6);   // SW, 4th retire wraps
      run(7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 0, 0, 1, 3);   // BEQ taken
      run(7'b1100011, 3'b001, 7'b0000000, 0, 0, 0, 0, 0, 1, 3);   // BNE not taken
      run(7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 1, 3);   // JALR
      run(7'b1101111, 3'b000, 7'b0000000, 0, 2, 0, 0, 1, 3, 5);   // JAL, fetch waits
      run(7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 0, 1, 1, 4);   // SRAI
      run(7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0, 1, 4);   // ADDI, never SUB
      run(7'b0110011, 3'b011, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // SLTU
      run(7'b0010011, 3'b110, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // ORI
      run(7'b0110011, 3'b111, 7'b0000000, 0, 1, 0, 0, 0, 2, 5);   // AND
      run(7'b0110011, 3'b001, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // SLL
      run(7'b0010011, 3'b010, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // SLTI
      run(7'b0110011, 3'b100, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // XOR
      run(7'b0110011, 3'b101, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // SRL
      run(7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);   // LUI
      run(7'b0010111, 3'b000, 7'b0000000, 0, 1, 0, 0, 0, 2, 5);   // AUIPC
      run(7'b0000011, 3'b010, 7'b0000000, 0, 4, 4, 0, 0, 5, 13);  // LW, waits at timeout limit
      run(7'b0000011, 3'b000, 7'b0000000, 0, 1, 0, 0, 1, 2, 6);   // LB, stray mack
      run(7'b0100011, 3'b000, 7'b0000000, 0, 0, 4, 0, 0, 1, 8);   // SB, 4 mem waits
      // illegal opcode, 20 trapped cycles, then reset
      run(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, 22, 1, 1, 0);
      do_rst(1);
      // fetch never acked
      run(7'b0110011, 3'b000, 7'b0000000, 0, 99, 0, 10, 0, 0, 0);
      do_rst(1);
      // store never acked
      run(7'b0100011, 3'b010, 7'b0000000, 0, 0, 99, 12, 0, 1, 0);
      do_rst(1);
      // reset while a store is waiting in MEM
      run(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);
      run(7'b0100011, 3'b010, 7'b0000000, 0, 0, 10, 5, 0, 1, 0);
      do_rst(1);
      run(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 1, 4);
      run(7'b0010011, 3'b100, 7'b0000000, 0, 0, 1, 0, 0, 1, 4);   // XORI, mw unused
      chk = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
